spi_burst_writer: RTL and testbench

- Sequencer directly upstream of spi_memory_master. Turns a byte stream plus start address/length into one SPI memory page-program (opcode 8'h02) transaction.
- Drives the master's level triggers (opcode_addr_trigger, data_trigger, finalize_trigger) and consumes its completion strobes.
- Sits between the pixel/line buffer and the SPI memory master in the camera write path.

---
 rtl/spi_burst_writer.sv | 129 ++++++++++++
 tb/tb_spi_burst_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_writer.sv
// rtl/spi_burst_writer.sv - page-program burst sequencer feeding spi_memory_master (option: SPI_BURST_PAGE_SPLIT_EN)
module spi_burst_writer #(
    parameter int          ADDR_W = 8,
    parameter int          LEN_W  = 9,
    parameter logic [7:0]  OPCODE = 8'h02
) (
    input  logic              main_clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        opcode,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        write_data,
    output logic              opcode_addr_trigger,
    output logic              addr_flag,
    output logic              data_trigger,
    output logic              finalize_trigger,
    input  logic              opcode_addr_completed,
    input  logic              data_ready,
    input  logic              data_completed,
    input  logic              busy,
    output logic              active,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CMD, S_DATA, S_DRAIN, S_FIN, S_DONE
    } state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   remaining;
    logic [ADDR_W-1:0]  addr_next;
    logic               cmd_issued;
    logic               split_pend;
    logic               fin_seen;
    logic               dc_pend;
    logic               prev_oac, prev_dr, prev_dc;
    logic               oac_rise, dr_rise, dc_rise;
    logic               page_cross;

    assign oac_rise  = opcode_addr_completed & ~prev_oac;
    assign dr_rise   = data_ready & ~prev_dr;
    assign dc_rise   = data_completed & ~prev_dc;
    assign addr_next = addr + ADDR_W'(1);

`ifdef SPI_BURST_PAGE_SPLIT_EN
    assign page_cross = (addr_next[7:0] == 8'h00) && (remaining != '0);
`else
    assign page_cross = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (length == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (in_valid) state_n = cmd_issued ? S_DATA : S_CMD;
            S_CMD:   if (oac_rise) state_n = S_DATA;
            S_DATA:  if (dr_rise) state_n = ((remaining == '0) || page_cross) ? S_DRAIN : S_LOAD;
            S_DRAIN: if (dc_rise || dc_pend) state_n = S_FIN;
            // busy is only trusted once the master has seen finalize for a cycle
            S_FIN:   if (fin_seen && !busy) state_n = split_pend ? S_LOAD : S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            remaining  <= '0;
            write_data <= 8'h00;
            cmd_issued <= 1'b0;
            split_pend <= 1'b0;
            fin_seen   <= 1'b0;
            dc_pend    <= 1'b0;
            prev_oac   <= 1'b0;
            prev_dr    <= 1'b0;
            prev_dc    <= 1'b0;
        end else begin
            state    <= state_n;
            prev_oac <= opcode_addr_completed;
            prev_dr  <= data_ready;
            prev_dc  <= data_completed;
            fin_seen <= (state == S_FIN) && (state_n == S_FIN);
            if (dc_rise) dc_pend <= 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    addr       <= start_addr;
                    remaining  <= length;
                    cmd_issued <= 1'b0;
                    split_pend <= 1'b0;
                    dc_pend    <= 1'b0;
                end
                S_LOAD: if (in_valid) begin
                    write_data <= in_data;
                    remaining  <= remaining - LEN_W'(1);
                end
                S_CMD: cmd_issued <= 1'b1;
                // completions seen before this capture belong to earlier bytes
                S_DATA: if (dr_rise) begin
                    addr    <= addr_next;
                    dc_pend <= dc_rise;
                    if (page_cross) split_pend <= 1'b1;
                end
                S_DRAIN: if (state_n == S_FIN) dc_pend <= 1'b0;
                S_FIN: if (state_n != S_FIN) begin
                    cmd_issued <= 1'b0;
                    split_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready            = (state == S_LOAD) && in_valid;
    assign opcode              = OPCODE;
    assign addr_flag           = 1'b1;
    assign opcode_addr_trigger = (state == S_CMD) || cmd_issued;
    assign data_trigger        = (state == S_DATA);
    assign finalize_trigger    = (state == S_FIN);
    assign active              = (state != S_IDLE);
    assign done                = (state == S_DONE);

endmodule

// File: tb/tb_spi_burst_writer.sv
// tb/tb_spi_burst_writer.sv - scoreboard bench for spi_burst_writer with a behavioural SPI master
module tb_spi_burst_writer;

    logic        main_clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  length;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [7:0]  addr;
    logic [7:0]  write_data;
    logic        opcode_addr_trigger;
    logic        addr_flag;
    logic        data_trigger;
    logic        finalize_trigger;
    logic        opcode_addr_completed;
    logic        data_ready;
    logic        data_completed;
    logic        busy;
    logic        active;
    logic        done;

    spi_burst_writer dut (
        .main_clock(main_clock), .reset_n(reset_n), .start(start),
        .start_addr(start_addr), .length(length), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .addr(addr),
        .write_data(write_data), .opcode_addr_trigger(opcode_addr_trigger),
        .addr_flag(addr_flag), .data_trigger(data_trigger),
        .finalize_trigger(finalize_trigger),
        .opcode_addr_completed(opcode_addr_completed), .data_ready(data_ready),
        .data_completed(data_completed), .busy(busy), .active(active), .done(done)
    );

    always #5 main_clock = ~main_clock;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [7:0]  exp_addr[$];
    logic [7:0]  exp_byte[$];
    logic [23:0] exp_tok[$];

    int n_cmd, n_fin, n_bytes, n_inr, n_trig, n_done, done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge main_clock);
        cyc++;
    end

    // Behavioural master: accepts a new byte only after the previous one finished shifting
    initial begin : master
        logic m_oat_prev;
        int oa_timer, dr_timer, dc_timer, fin_timer;
        opcode_addr_completed = 0; data_ready = 0; data_completed = 0; busy = 0;
        m_oat_prev = 0; oa_timer = 0; dr_timer = 0; dc_timer = 0; fin_timer = 0;
        forever begin
            @(negedge main_clock);
            if (!reset_n) begin
                opcode_addr_completed = 0; data_ready = 0; data_completed = 0; busy = 0;
                m_oat_prev = 0; oa_timer = 0; dr_timer = 0; dc_timer = 0; fin_timer = 0;
            end else begin
                if (opcode_addr_trigger && !m_oat_prev) begin
                    busy = 1;
                    oa_timer = 3;
                end
                m_oat_prev = opcode_addr_trigger;
                if (!opcode_addr_trigger) opcode_addr_completed = 0;
                else if (oa_timer > 0) begin
                    oa_timer--;
                    if (oa_timer == 0) opcode_addr_completed = 1;
                end
                data_completed = 0;
                if (dc_timer > 0) begin
                    dc_timer--;
                    if (dc_timer == 0) data_completed = 1;
                end
                if (!data_trigger) begin
                    data_ready = 0;
                    dr_timer = 0;
                end else if (!data_ready && dc_timer == 0 && !data_completed) begin
                    dr_timer++;
                    if (dr_timer == 2) begin
                        data_ready = 1;
                        dc_timer = 3;
                    end
                end
                if (finalize_trigger) begin
                    fin_timer++;
                    if (fin_timer == 3) busy = 0;
                end else fin_timer = 0;
            end
        end
    end

    initial begin : monitor
        logic p_oat, p_fin, p_dt, p_dr;
        logic [7:0] wd_trig;
        p_oat = 0; p_fin = 0; p_dt = 0; p_dr = 0; wd_trig = 0;
        n_cmd = 0; n_fin = 0; n_bytes = 0; n_inr = 0; n_trig = 0; n_done = 0; done_cyc = 0;
        forever begin
            @(negedge main_clock);
            #1;
            if (!reset_n) begin
                n_cmd = 0; n_fin = 0; n_bytes = 0;
                p_oat = 0; p_fin = 0; p_dt = 0; p_dr = 0;
            end else begin
                if (opcode_addr_trigger && !p_oat) begin
                    n_cmd++;
                    if (exp_addr.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
                    else chk("cmd_addr", {24'h0, addr}, {24'h0, exp_addr.pop_front()});
                end
                if (finalize_trigger && !p_fin) n_fin++;
                if (data_trigger && !p_dt) wd_trig = write_data;
                if (data_ready && !p_dr) begin
                    n_bytes++;
                    chk("wd_stable", {24'h0, write_data}, {24'h0, wd_trig});
                    if (exp_byte.size() == 0) chk("byte_unexpected", 32'd1, 32'd0);
                    else chk("byte", {24'h0, write_data}, {24'h0, exp_byte.pop_front()});
                end
                if (in_ready) n_inr++;
                if (opcode_addr_trigger || data_trigger || finalize_trigger) n_trig++;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    if (exp_tok.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                    else chk("done_phases", {8'h0, n_cmd[7:0], n_fin[7:0], n_bytes[7:0]},
                             {8'h0, exp_tok.pop_front()});
                    n_cmd = 0; n_fin = 0; n_bytes = 0;
                end
                p_oat = opcode_addr_trigger;
                p_fin = finalize_trigger;
                p_dt  = data_trigger;
                p_dr  = data_ready;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] a, input int len);
        @(negedge main_clock);
        start_addr = a;
        length     = 9'(len);
        start      = 1;
        @(negedge main_clock);
        start = 0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int k;
        for (k = 0; k < 2000 && n_done == d0; k++) @(negedge main_clock);
        if (n_done == d0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic feed_byte(input logic [7:0] b);
        int k;
        bit got;
        got = 0;
        in_data  = b;
        in_valid = 1;
        for (k = 0; k < 500 && !got; k++) begin
            #1;
            if (in_ready) got = 1;
            @(negedge main_clock);
        end
        in_valid = 0;
        if (!got) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_burst(input logic [7:0] a, input int len, input logic [7:0] base,
                              input int stall_idx, input bit extra_start, input string name);
        int d0, r0;
        d0 = n_done;
        r0 = n_inr;
        for (int i = 0; i < len; i++) exp_byte.push_back(base + 8'(i));
        pulse_start(a, len);
        for (int i = 0; i < len; i++) begin
            if (i == stall_idx) begin
                repeat (10) @(negedge main_clock);
                #1;
                chk({name, "_stall_dtrig"}, {31'h0, data_trigger}, 32'd0);
                chk({name, "_stall_oat"}, {31'h0, opcode_addr_trigger}, 32'd1);
                chk({name, "_stall_inready"}, {31'h0, in_ready}, 32'd0);
            end
            if (extra_start && i == 1) begin
                start_addr = 8'h77;
                length     = 9'd5;
                start      = 1;
                @(negedge main_clock);
                start      = 0;
            end
            feed_byte(base + 8'(i));
        end
        wait_done(d0, name);
        repeat (20) @(negedge main_clock);
        chk({name, "_done_once"}, n_done - d0, 32'd1);
        chk({name, "_inready_cnt"}, n_inr - r0, len);
        chk({name, "_active_idle"}, {31'h0, active}, 32'd0);
    endtask

    initial begin
        int d0, r0, t0, s_cyc, k;
        reset_n = 0; start = 0; start_addr = 0; length = 0; in_data = 0; in_valid = 0;
        repeat (3) @(negedge main_clock);
        #1;
        chk("rst_oat", {31'h0, opcode_addr_trigger}, 32'd0);
        chk("rst_dtrig", {31'h0, data_trigger}, 32'd0);
        chk("rst_fin", {31'h0, finalize_trigger}, 32'd0);
        chk("rst_inready", {31'h0, in_ready}, 32'd0);
        chk("rst_active", {31'h0, active}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_wdata", {24'h0, write_data}, 32'h0);
        chk("rst_addr", {24'h0, addr}, 32'h0);
        chk("opcode", {24'h0, opcode}, 32'h02);
        chk("addr_flag", {31'h0, addr_flag}, 32'd1);
        @(negedge main_clock);
        reset_n = 1;
        repeat (2) @(negedge main_clock);

        // single byte
        exp_addr.push_back(8'hAB);
        exp_tok.push_back({8'd1, 8'd1, 8'd1});
        send_burst(8'hAB, 1, 8'h12, -1, 0, "single");

        // four bytes with a stall before the third
        exp_addr.push_back(8'h20);
        exp_tok.push_back({8'd1, 8'd1, 8'd4});
        send_burst(8'h20, 4, 8'h01, 2, 0, "stall");

        // zero length
        d0 = n_done; r0 = n_inr; t0 = n_trig;
        exp_tok.push_back({8'd0, 8'd0, 8'd0});
        @(negedge main_clock);
        start_addr = 8'h33; length = 9'd0; start = 1;
        s_cyc = cyc;
        @(negedge main_clock);
        start = 0;
        wait_done(d0, "zero");
        chk("zero_done_latency", done_cyc - s_cyc, 32'd1);
        repeat (10) @(negedge main_clock);
        chk("zero_done_once", n_done - d0, 32'd1);
        chk("zero_no_trigger", n_trig - t0, 32'd0);
        chk("zero_no_inready", n_inr - r0, 32'd0);

        // second start while active is ignored
        exp_addr.push_back(8'h50);
        exp_tok.push_back({8'd1, 8'd1, 8'd2});
        send_burst(8'h50, 2, 8'h30, -1, 1, "restart");

        // reset while in DATA
        exp_addr.push_back(8'h40);
        pulse_start(8'h40, 3);
        in_data = 8'hA0; in_valid = 1;
        for (k = 0; k < 500 && !data_trigger; k++) @(negedge main_clock);
        in_valid = 0;
        reset_n = 0;
        #1;
        chk("mid_rst_seen_data", k < 500, 32'd1);
        chk("mid_rst_oat", {31'h0, opcode_addr_trigger}, 32'd0);
        chk("mid_rst_dtrig", {31'h0, data_trigger}, 32'd0);
        chk("mid_rst_fin", {31'h0, finalize_trigger}, 32'd0);
        chk("mid_rst_active", {31'h0, active}, 32'd0);
        repeat (2) @(negedge main_clock);
        reset_n = 1;
        repeat (2) @(negedge main_clock);
        exp_addr.push_back(8'h10);
        exp_tok.push_back({8'd1, 8'd1, 8'd2});
        send_burst(8'h10, 2, 8'h55, -1, 0, "after_rst");

        // page crossing
`ifdef SPI_BURST_PAGE_SPLIT_EN
        exp_addr.push_back(8'hFE);
        exp_addr.push_back(8'h00);
        exp_tok.push_back({8'd2, 8'd2, 8'd4});
`else
        exp_addr.push_back(8'hFE);
        exp_tok.push_back({8'd1, 8'd1, 8'd4});
`endif
        send_burst(8'hFE, 4, 8'hC0, -1, 0, "page");

        chk("left_addr", exp_addr.size(), 32'd0);
        chk("left_byte", exp_byte.size(), 32'd0);
        chk("left_tok", exp_tok.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
